keypad_scan_fifo: RTL and testbench
===================================

Name: keypad_scan_fifo

Overview:
Parametrised keypad scanner for the MMIO peripheral path. It drives keypad rows one-hot, samples the column inputs, and debounces complete scans. Each debounced key press becomes a single key-code event pushed into a FIFO. The CPU reads the FIFO head through the MMIO read mux and pops it with a read strobe. This block replaces the single-register keypad, which reports only the instantaneous button.

Parameters:
NUM_ROWS, 4, number of row drive lines (>=2)
NUM_COLS, 3, number of column sense lines (>=1)
SCAN_CYCLES, 30000, clock cycles each row is driven (>=4)
DEBOUNCE_SCANS, 4, consecutive identical full-scan results needed to accept a state (>=2)
FIFO_DEPTH, 8, event FIFO entries (power of two, >=2)
CODE_WIDTH, 4, key-code width (>= clog2(NUM_ROWS*NUM_COLS))

Ports:
clock  in  1  system clock; all state on posedge
reset  in  1  asynchronous, active-high
cols  in  NUM_COLS  raw column inputs; bit c high = key at (driven row, c) closed
rows  out  NUM_ROWS  one-hot active-high row drive
pop  in  1  MMIO read strobe; removes head entry
clear_overflow  in  1  clears the overflow flag
key_code  out  CODE_WIDTH  FIFO head; 0 when empty
key_valid  out  1  FIFO not empty
fifo_count  out  clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky: a push was dropped
held  out  1  debounced state is a single pressed key

Behaviour:
- Reset (async, immediate): rows=1 (row 0); scan counter, row index and stable count = 0; last and debounced candidates = NONE; FIFO empty; key_code=0, key_valid=0, fifo_count=0, overflow=0, held=0.
- cols pass through a 2-flop synchroniser before use.
- Scan: row r is driven for SCAN_CYCLES cycles. Synchronised cols are sampled on dwell cycle SCAN_CYCLES-1 and OR-accumulated per row into a scan image. The row index then advances and wraps from NUM_ROWS-1 to 0.
- End of scan (sample of row NUM_ROWS-1). The candidate is:
  - NONE if the image has no set bits;
  - KEY(code), with code = row*NUM_COLS + col, if exactly one bit is set;
  - MULTI if two or more bits are set.
  The image is then cleared.
- Debounce, evaluated once per scan:
  - If candidate == last candidate, stable_count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise last = candidate and stable_count = 1.
  - When stable_count becomes DEBOUNCE_SCANS and candidate != MULTI, debounced state = candidate.
  - If that new debounced state is KEY(code) and differs from the previous debounced state, push code on the next clock.
- MULTI never changes the debounced state. Release produces no event. A key held indefinitely produces exactly one event.
- held = 1 iff the debounced state is KEY.
- FIFO:
  - Registered storage; key_code reads combinationally from the head entry.
  - Push when not full: write at tail, count+1.
  - Pop when not empty: head advances, count-1.
  - Pop when empty: ignored.
  - Push and pop in the same cycle while non-empty: both occur, count unchanged. This includes when full, and then no overflow is raised.
  - Push when full without pop: event dropped, overflow=1.
  - overflow stays set until clear_overflow. If a clear coincides with a new drop, the set wins.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: the push edge is 1 cycle after the qualifying end-of-scan sample. key_valid and fifo_count update on that same edge.
- Reset mid-operation: all state is discarded. A key held through reset re-reports once after DEBOUNCE_SCANS full scans.

Test Plan:
Bench parameters: SCAN_CYCLES=4, DEBOUNCE_SCANS=3, FIFO_DEPTH=4; 4x3 matrix model (cols[c]=1 while rows[r] is high and key (r,c) is closed).
1. Reset then run 20 cycles -> rows sequence 0001,0010,0100,1000,0001, changing every 4 cycles; all other outputs 0.
2. Close key (2,1) for 6 scans -> exactly one push; key_code=7, key_valid=1, fifo_count=1, held=1. Open the key -> held=0 after 3 scans; fifo_count stays 1.
3. Bounce key (0,0) on alternate scans for 8 scans -> no push, held=0. Close keys (1,0) and (3,2) together for 5 scans -> no push.
4. Press/release codes 1,4,5,9,10 without popping -> fifo_count=4, overflow=1, key_code=1. Four pops -> key_code 1,4,5,9, then key_valid=0 and key_code=0. Fifth pop ignored. clear_overflow -> overflow=0.
5. Fill to 4 entries, then assert pop in the push cycle of a new code 11 -> fifo_count stays 4, overflow=0, tail holds 11.
6. With fifo_count=2 and mid-dwell on row 2, assert reset asynchronously -> fifo_count=0, key_valid=0 and rows=0001 before the next clock edge. Key held through reset -> exactly one event after 3 scans.

Source files
------------

// File: rtl/keypad_scan_fifo_if.sv
// CPU-facing side of the keypad scanner: pop/clear strobes in, FIFO head and status out.
interface keypad_scan_fifo_if #(
  parameter int CODE_WIDTH = 4,
  parameter int FIFO_DEPTH = 8
);
  logic                        pop;
  logic                        clear_overflow;
  logic [CODE_WIDTH-1:0]       key_code;
  logic                        key_valid;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        overflow;
  logic                        held;

  modport master (
    output pop, clear_overflow,
    input  key_code, key_valid, fifo_count, overflow, held
  );
  modport slave (
    input  pop, clear_overflow,
    output key_code, key_valid, fifo_count, overflow, held
  );
endinterface

// File: rtl/keypad_scan_fifo.sv
// Row-scanning keypad reader: debounces whole-matrix scans and queues one key code per
// accepted press into a small FIFO read by the CPU.
module keypad_scan_fifo #(
  parameter int NUM_ROWS       = 4,
  parameter int NUM_COLS       = 3,
  parameter int SCAN_CYCLES    = 30000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int CODE_WIDTH     = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] cols,
  output logic [NUM_ROWS-1:0] rows,
  keypad_scan_fifo_if.slave   bus
);
  localparam int KEYS  = NUM_ROWS * NUM_COLS;
  localparam int CNT_W = $clog2(SCAN_CYCLES);
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNF_W = PTR_W + 1;

  typedef enum logic [1:0] {CAND_NONE = 2'd0, CAND_KEY = 2'd1, CAND_MULTI = 2'd2} cand_e;

  logic [NUM_COLS-1:0] cols_meta_q, cols_sync_q;
  logic [CNT_W-1:0]    dwell_q, dwell_d;
  logic [ROW_W-1:0]    row_idx_q, row_idx_d;
  logic [NUM_ROWS-1:0] rows_q, rows_d;
  logic [KEYS-1:0]     image_q, image_d, img_s;
  cand_e               last_kind_q, last_kind_d, deb_kind_q, deb_kind_d, cand_kind_s;
  logic [CODE_WIDTH-1:0] last_code_q, last_code_d, deb_code_q, deb_code_d;
  logic [CODE_WIDTH-1:0] hit_code_s, cand_code_s, push_code_q, push_code_d;
  logic [STB_W-1:0]    stable_q, stable_d;
  logic                push_q, push_d;
  logic [1:0]          hits_s;
  logic                sample_s, scan_end_s;
  logic [FIFO_DEPTH-1:0][CODE_WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNF_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                empty_s, full_s, do_pop_s, do_push_s, drop_s;

  // Row dwell timing, scan image accumulation and candidate classification.
  always_comb begin
    sample_s   = (dwell_q == CNT_W'(SCAN_CYCLES - 1));
    scan_end_s = sample_s && (row_idx_q == ROW_W'(NUM_ROWS - 1));
    if (sample_s) begin
      dwell_d   = '0;
      row_idx_d = (row_idx_q == ROW_W'(NUM_ROWS - 1)) ? '0 : row_idx_q + ROW_W'(1);
    end else begin
      dwell_d   = dwell_q + CNT_W'(1);
      row_idx_d = row_idx_q;
    end
    rows_d = NUM_ROWS'(1) << row_idx_d;

    img_s = image_q;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (sample_s && (row_idx_q == ROW_W'(r))) begin
          img_s[r*NUM_COLS+c] = image_q[r*NUM_COLS+c] | cols_sync_q[c];
        end else begin
          img_s[r*NUM_COLS+c] = image_q[r*NUM_COLS+c];
        end
      end
    end
    image_d = scan_end_s ? '0 : img_s;

    // Bit index equals row*NUM_COLS+col, so the last set bit is the key code when only one is set.
    hits_s     = 2'd0;
    hit_code_s = '0;
    for (int k = 0; k < KEYS; k++) begin
      hit_code_s = img_s[k] ? CODE_WIDTH'(k) : hit_code_s;
      hits_s     = (img_s[k] && (hits_s != 2'd2)) ? hits_s + 2'd1 : hits_s;
    end
    case (hits_s)
      2'd0:    cand_kind_s = CAND_NONE;
      2'd1:    cand_kind_s = CAND_KEY;
      default: cand_kind_s = CAND_MULTI;
    endcase
    cand_code_s = (cand_kind_s == CAND_KEY) ? hit_code_s : '0;
  end

  // Debounce across scans; a push is armed only on a transition into a new pressed key.
  always_comb begin
    last_kind_d = last_kind_q;
    last_code_d = last_code_q;
    stable_d    = stable_q;
    deb_kind_d  = deb_kind_q;
    deb_code_d  = deb_code_q;
    push_d      = 1'b0;
    push_code_d = push_code_q;
    if (scan_end_s) begin
      if ((cand_kind_s == last_kind_q) && (cand_code_s == last_code_q)) begin
        stable_d = (stable_q == STB_W'(DEBOUNCE_SCANS)) ? stable_q : stable_q + STB_W'(1);
      end else begin
        last_kind_d = cand_kind_s;
        last_code_d = cand_code_s;
        stable_d    = STB_W'(1);
      end
      if ((stable_d == STB_W'(DEBOUNCE_SCANS)) && (cand_kind_s != CAND_MULTI)) begin
        deb_kind_d = cand_kind_s;
        deb_code_d = cand_code_s;
        if ((cand_kind_s == CAND_KEY) &&
            ((deb_kind_q != CAND_KEY) || (deb_code_q != cand_code_s))) begin
          push_d      = 1'b1;
          push_code_d = cand_code_s;
        end else begin
          push_d = 1'b0;
        end
      end else begin
        deb_kind_d = deb_kind_q;
      end
    end else begin
      stable_d = stable_q;
    end
  end

  // Event FIFO; a pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    empty_s    = (count_q == '0);
    full_s     = (count_q == CNF_W'(FIFO_DEPTH));
    do_pop_s   = bus.pop && !empty_s;
    do_push_s  = push_q && (!full_s || do_pop_s);
    drop_s     = push_q && full_s && !do_pop_s;
    mem_d      = mem_q;
    if (do_push_s) begin
      mem_d[tail_q] = push_code_q;
    end else begin
      mem_d = mem_q;
    end
    head_d = do_pop_s  ? head_q + PTR_W'(1) : head_q;
    tail_d = do_push_s ? tail_q + PTR_W'(1) : tail_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNF_W'(1);
      2'b01:   count_d = count_q - CNF_W'(1);
      default: count_d = count_q;
    endcase
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (bus.clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cols_meta_q <= '0;
      cols_sync_q <= '0;
      dwell_q     <= '0;
      row_idx_q   <= '0;
      rows_q      <= NUM_ROWS'(1);
      image_q     <= '0;
      last_kind_q <= CAND_NONE;
      last_code_q <= '0;
      stable_q    <= '0;
      deb_kind_q  <= CAND_NONE;
      deb_code_q  <= '0;
      push_q      <= 1'b0;
      push_code_q <= '0;
      mem_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      cols_meta_q <= cols;
      cols_sync_q <= cols_meta_q;
      dwell_q     <= dwell_d;
      row_idx_q   <= row_idx_d;
      rows_q      <= rows_d;
      image_q     <= image_d;
      last_kind_q <= last_kind_d;
      last_code_q <= last_code_d;
      stable_q    <= stable_d;
      deb_kind_q  <= deb_kind_d;
      deb_code_q  <= deb_code_d;
      push_q      <= push_d;
      push_code_q <= push_code_d;
      mem_q       <= mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  assign rows           = rows_q;
  assign bus.key_code   = empty_s ? '0 : mem_q[head_q];
  assign bus.key_valid  = !empty_s;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.held       = (deb_kind_q == CAND_KEY);
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo with a scan/debounce/queue model checked every cycle.
module tb_keypad_scan_fifo;
  localparam int NR = 4, NC = 3, SC = 4, DB = 3, FD = 4, CW = 4;
  localparam int SCAN  = NR * SC;
  localparam int NONE  = -1;
  localparam int MULTI = -2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NR*NC-1:0] keys = '0;
  logic [NC-1:0] cols;
  logic [NR-1:0] rows;

  keypad_scan_fifo_if #(.CODE_WIDTH(CW), .FIFO_DEPTH(FD)) bus ();

  keypad_scan_fifo #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .SCAN_CYCLES(SC),
    .DEBOUNCE_SCANS(DB), .FIFO_DEPTH(FD), .CODE_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .cols(cols), .rows(rows), .bus(bus)
  );

  always #5 clock = ~clock;

  // Keypad matrix: a closed key connects its row drive to its column sense.
  always_comb begin
    cols = '0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (rows[r] && keys[r*NC+c]) cols[c] = 1'b1;
  end

  int n_pass = 0, n_total = 0;

  int m_cyc, m_last, m_stable, m_deb, m_pend_code;
  bit m_pend, m_ovf;
  logic [NC-1:0] m_s1, m_s2;
  logic [NR*NC-1:0] m_img;
  int m_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_cyc = 0; m_last = NONE; m_stable = 0; m_deb = NONE;
    m_pend = 1'b0; m_pend_code = 0; m_ovf = 1'b0;
    m_s1 = '0; m_s2 = '0; m_img = '0;
    m_q.delete();
  endtask

  // One rising edge of the model, from the inputs that hold just before it.
  task automatic model_edge();
    int row, n, cand;
    bit pop_ok, was_full;
    logic [NC-1:0] cin;
    if (reset) begin
      model_reset();
      return;
    end
    row = (m_cyc / SC) % NR;
    cin = '0;
    for (int c = 0; c < NC; c++) if (keys[row*NC+c]) cin[c] = 1'b1;
    pop_ok   = bus.pop && (m_q.size() > 0);
    was_full = (m_q.size() == FD);
    if (pop_ok) void'(m_q.pop_front());
    if (m_pend && (!was_full || pop_ok)) m_q.push_back(m_pend_code);
    if (m_pend && was_full && !pop_ok) m_ovf = 1'b1;
    else if (bus.clear_overflow) m_ovf = 1'b0;
    m_pend = 1'b0;
    if (m_cyc % SC == SC - 1) begin
      for (int c = 0; c < NC; c++) if (m_s2[c]) m_img[row*NC+c] = 1'b1;
      if (row == NR - 1) begin
        n = 0; cand = NONE;
        for (int k = 0; k < NR*NC; k++) if (m_img[k]) begin n++; cand = k; end
        if (n > 1) cand = MULTI;
        if (cand == m_last) m_stable = (m_stable < DB) ? m_stable + 1 : DB;
        else begin m_last = cand; m_stable = 1; end
        if (m_stable == DB && cand != MULTI) begin
          if (cand >= 0 && cand != m_deb) begin m_pend = 1'b1; m_pend_code = cand; end
          m_deb = cand;
        end
        m_img = '0;
      end
    end
    m_s2 = m_s1;
    m_s1 = cin;
    m_cyc++;
  endtask

  task automatic compare_all();
    logic [13:0] e, a;
    e = {NR'(1 << ((m_cyc / SC) % NR)),
         CW'((m_q.size() > 0) ? m_q[0] : 0),
         (m_q.size() > 0) ? 1'b1 : 1'b0,
         3'(m_q.size()),
         m_ovf,
         (m_deb >= 0) ? 1'b1 : 1'b0};
    a = {rows, bus.key_code, bus.key_valid, bus.fifo_count, bus.overflow, bus.held};
    chk("cycle_outputs", 32'(a), 32'(e));
  endtask

  task automatic step();
    model_edge();
    @(negedge clock);
    compare_all();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press_release(int code);
    keys[code] = 1'b1; run(5*SCAN);
    keys[code] = 1'b0; run(5*SCAN);
  endtask

  task automatic pop_once();
    bus.pop = 1'b1; step(); bus.pop = 1'b0;
  endtask

  logic [3:0] rows_tab [5];
  int codes_a [4];
  bit hit;

  initial begin
    rows_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    codes_a  = '{1, 4, 5, 9};
    bus.pop = 1'b0;
    bus.clear_overflow = 1'b0;
    model_reset();
    run(2);

    // 1: reset state and row walk
    chk("reset_rows", 32'(rows), 32'd1);
    chk("reset_outs", 32'({bus.key_code, bus.key_valid, bus.fifo_count, bus.overflow, bus.held}), 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k % 4 == 3) chk("row_walk", 32'(rows), 32'(rows_tab[k/4]));
    end
    chk("idle_outs", 32'({bus.key_code, bus.key_valid, bus.fifo_count, bus.overflow, bus.held}), 32'd0);

    // 2: single press of (2,1), then release
    keys[7] = 1'b1; run(6*SCAN);
    chk("press_code", 32'(bus.key_code), 32'd7);
    chk("press_valid", 32'(bus.key_valid), 32'd1);
    chk("press_count", 32'(bus.fifo_count), 32'd1);
    chk("press_held", 32'(bus.held), 32'd1);
    keys[7] = 1'b0; run(5*SCAN);
    chk("release_held", 32'(bus.held), 32'd0);
    chk("release_count", 32'(bus.fifo_count), 32'd1);

    // 3: bouncing key and two-key chord give no event
    for (int i = 0; i < 8; i++) begin keys[0] = (i % 2 == 0); run(SCAN); end
    keys = '0; run(4*SCAN);
    chk("bounce_count", 32'(bus.fifo_count), 32'd1);
    chk("bounce_held", 32'(bus.held), 32'd0);
    keys[3] = 1'b1; keys[11] = 1'b1; run(5*SCAN);
    chk("multi_count", 32'(bus.fifo_count), 32'd1);
    chk("multi_held", 32'(bus.held), 32'd0);
    keys = '0; run(4*SCAN);
    pop_once();
    chk("drain_count", 32'(bus.fifo_count), 32'd0);

    // 4: overflow, ordered pops, empty pop, clear
    press_release(1); press_release(4); press_release(5); press_release(9); press_release(10);
    chk("ovf_count", 32'(bus.fifo_count), 32'd4);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("pop_order", 32'(bus.key_code), 32'(codes_a[i]));
      pop_once();
    end
    chk("empty_valid", 32'(bus.key_valid), 32'd0);
    chk("empty_code", 32'(bus.key_code), 32'd0);
    pop_once();
    chk("empty_pop", 32'(bus.fifo_count), 32'd0);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    bus.clear_overflow = 1'b1; step(); bus.clear_overflow = 1'b0;
    chk("ovf_clear", 32'(bus.overflow), 32'd0);

    // 5: push and pop together while full
    press_release(2); press_release(3); press_release(6); press_release(8);
    chk("full_count", 32'(bus.fifo_count), 32'd4);
    keys[11] = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 6*SCAN && !hit; i++) begin
      if (m_pend) begin pop_once(); hit = 1'b1; end
      else step();
    end
    chk("push_seen", 32'(hit), 32'd1);
    keys[11] = 1'b0; run(5*SCAN);
    chk("pp_count", 32'(bus.fifo_count), 32'd4);
    chk("pp_ovf", 32'(bus.overflow), 32'd0);
    pop_once(); pop_once(); pop_once();
    chk("pp_tail", 32'(bus.key_code), 32'd11);

    // 6: asynchronous reset mid-dwell with a key held through it
    keys[5] = 1'b1; run(5*SCAN);
    chk("pre_rst_count", 32'(bus.fifo_count), 32'd2);
    for (int i = 0; i < SCAN && !((m_cyc % SC == 1) && ((m_cyc / SC) % NR == 2)); i++) step();
    chk("pre_rst_row", 32'(rows), 32'b0100);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("async_count", 32'(bus.fifo_count), 32'd0);
    chk("async_valid", 32'(bus.key_valid), 32'd0);
    chk("async_rows", 32'(rows), 32'd1);
    step();
    reset = 1'b0;
    run(6*SCAN);
    chk("rereport_count", 32'(bus.fifo_count), 32'd1);
    chk("rereport_code", 32'(bus.key_code), 32'd5);
    chk("rereport_held", 32'(bus.held), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
